control_multiciclo: RTL and testbench

CONTROL_MULTICICLO -- requirements
Module: control_multiciclo

---
 rtl/control_multiciclo.sv | 176 +++++++++++++++++
 tb/tb_control_multiciclo.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/control_multiciclo.sv
// control_multiciclo: control FSM for a multicycle RV32 datapath supporting
// R-type, ALU-immediate, load, store and BEQ/BNE.
//
// Ports:
//   clk_i, rst_ni            clock, async active-low reset
//   opcode_i, funct3_i       fields from the instruction register
//   zero_i                   ALU zero flag (branch compare)
//   mem_ready_i              memory handshake (only meaningful with mem_req_o)
//   mem_req_o/mem_we_o/iord_o, ir_we_o/pc_we_o/pcsrc_o,
//   alusrca_o/alusrcb_o/aluop_o, regwrite_o/memtoreg_o/branch_o/illegal_o
//                            datapath controls
//   state_o                  current state code
//   retired_o                completed-instruction counter (wraps)
module control_multiciclo #(
  parameter int RETIRE_W = 32
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic [6:0]          opcode_i,
  input  logic [2:0]          funct3_i,
  input  logic                zero_i,
  input  logic                mem_ready_i,
  output logic                mem_req_o,
  output logic                mem_we_o,
  output logic                iord_o,
  output logic                ir_we_o,
  output logic                pc_we_o,
  output logic                pcsrc_o,
  output logic                alusrca_o,
  output logic [1:0]          alusrcb_o,
  output logic [1:0]          aluop_o,
  output logic                regwrite_o,
  output logic                memtoreg_o,
  output logic                branch_o,
  output logic                illegal_o,
  output logic [2:0]          state_o,
  output logic [RETIRE_W-1:0] retired_o
);

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4
  } state_t;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IALU   = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  state_t state, state_nxt;

  logic       mem_req, mem_we, iord, ir_we, pc_we, pcsrc, alusrca;
  logic [1:0] alusrcb, aluop;
  logic       regwrite, memtoreg, branch, illegal, retire;
  logic       legal;

  assign legal = (opcode_i == OP_R) || (opcode_i == OP_IALU) ||
                 (opcode_i == OP_LOAD) || (opcode_i == OP_STORE) ||
                 (opcode_i == OP_BRANCH);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state     <= FETCH;
      retired_o <= '0;
    end else begin
      state <= state_nxt;
      if (retire) retired_o <= retired_o + 1'b1;
    end
  end

  always_comb begin
    state_nxt = FETCH;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    iord      = 1'b0;
    ir_we     = 1'b0;
    pc_we     = 1'b0;
    pcsrc     = 1'b0;
    alusrca   = 1'b0;
    alusrcb   = 2'b00;
    aluop     = 2'b00;
    regwrite  = 1'b0;
    memtoreg  = 1'b0;
    branch    = 1'b0;
    illegal   = 1'b0;
    retire    = 1'b0;
    case (state)
      FETCH: begin
        mem_req   = 1'b1;
        state_nxt = FETCH;
        if (mem_ready_i) begin
          // IR <- mem[PC], PC <- PC + 4 in the same cycle
          ir_we     = 1'b1;
          pc_we     = 1'b1;
          alusrcb   = 2'b01;
          state_nxt = DECODE;
        end
      end
      DECODE: begin
        // PC + imm precomputed into ALUOut for a possible branch
        alusrcb = 2'b10;
        if (legal) state_nxt = EXEC;
        else       illegal   = 1'b1;
      end
      EXEC: begin
        alusrca = 1'b1;
        case (opcode_i)
          OP_R: begin
            aluop     = 2'b10;
            state_nxt = WB;
          end
          OP_IALU: begin
            alusrcb   = 2'b10;
            aluop     = 2'b10;
            state_nxt = WB;
          end
          OP_LOAD, OP_STORE: begin
            alusrcb   = 2'b10;
            state_nxt = MEM;
          end
          OP_BRANCH: begin
            aluop  = 2'b01;
            branch = 1'b1;
            pcsrc  = 1'b1;
            // funct3[0] selects BNE: taken when the compare is not equal
            pc_we  = zero_i ^ funct3_i[0];
            retire = 1'b1;
          end
          default: ;
        endcase
      end
      MEM: begin
        mem_req   = 1'b1;
        iord      = 1'b1;
        mem_we    = (opcode_i == OP_STORE);
        state_nxt = MEM;
        if (mem_ready_i) begin
          if (opcode_i == OP_LOAD) begin
            state_nxt = WB;
          end else begin
            state_nxt = FETCH;
            retire    = (opcode_i == OP_STORE);
          end
        end
      end
      WB: begin
        regwrite = 1'b1;
        memtoreg = (opcode_i == OP_LOAD);
        retire   = 1'b1;
      end
      default: ;  // unused codes fall back to FETCH with everything idle
    endcase
  end

  // Combinational outputs are masked by reset so a pending memory access is
  // dropped immediately, without waiting for a clock edge.
  assign mem_req_o  = rst_ni & mem_req;
  assign mem_we_o   = rst_ni & mem_we;
  assign iord_o     = rst_ni & iord;
  assign ir_we_o    = rst_ni & ir_we;
  assign pc_we_o    = rst_ni & pc_we;
  assign pcsrc_o    = rst_ni & pcsrc;
  assign alusrca_o  = rst_ni & alusrca;
  assign alusrcb_o  = {2{rst_ni}} & alusrcb;
  assign aluop_o    = {2{rst_ni}} & aluop;
  assign regwrite_o = rst_ni & regwrite;
  assign memtoreg_o = rst_ni & memtoreg;
  assign branch_o   = rst_ni & branch;
  assign illegal_o  = rst_ni & illegal;
  assign state_o    = state;

endmodule

// File: tb/tb_control_multiciclo.sv
module tb_control_multiciclo;
  localparam int RW = 4;

  logic          clk = 1'b0;
  logic          rst_ni;
  logic [6:0]    opcode_i;
  logic [2:0]    funct3_i;
  logic          zero_i, mem_ready_i;
  logic          mem_req_o, mem_we_o, iord_o, ir_we_o, pc_we_o, pcsrc_o;
  logic          alusrca_o, regwrite_o, memtoreg_o, branch_o, illegal_o;
  logic [1:0]    alusrcb_o, aluop_o;
  logic [2:0]    state_o;
  logic [RW-1:0] retired_o;

  control_multiciclo #(.RETIRE_W(RW)) dut (
    .clk_i(clk), .rst_ni(rst_ni), .opcode_i(opcode_i), .funct3_i(funct3_i),
    .zero_i(zero_i), .mem_ready_i(mem_ready_i), .mem_req_o(mem_req_o),
    .mem_we_o(mem_we_o), .iord_o(iord_o), .ir_we_o(ir_we_o), .pc_we_o(pc_we_o),
    .pcsrc_o(pcsrc_o), .alusrca_o(alusrca_o), .alusrcb_o(alusrcb_o),
    .aluop_o(aluop_o), .regwrite_o(regwrite_o), .memtoreg_o(memtoreg_o),
    .branch_o(branch_o), .illegal_o(illegal_o), .state_o(state_o),
    .retired_o(retired_o)
  );

  always #5 clk = ~clk;

  localparam logic [6:0] R = 7'b0110011, IA = 7'b0010011, LD = 7'b0000011;
  localparam logic [6:0] ST = 7'b0100011, BR = 7'b1100011, BAD = 7'b1111111;

  typedef struct {
    string         tag;
    logic [2:0]    st;
    logic [14:0]   c;
    logic [RW-1:0] r;
  } exp_t;

  exp_t          sb[$];
  int            checks = 0;
  int            failures = 0;
  logic [RW-1:0] ret = '0;
  event          smp;

  function automatic logic [14:0] mk(input logic mreq, mwe, io, irw, pcw, pcs,
                                     asa, input logic [1:0] asb, aop,
                                     input logic rw, mtr, br, ill);
    return {mreq, mwe, io, irw, pcw, pcs, asa, asb, aop, rw, mtr, br, ill};
  endfunction

  initial begin
    forever begin
      @(negedge clk or smp);
      if (sb.size() > 0) begin
        exp_t e;
        logic [14:0] act;
        e = sb.pop_front();
        act = {mem_req_o, mem_we_o, iord_o, ir_we_o, pc_we_o, pcsrc_o,
               alusrca_o, alusrcb_o, aluop_o, regwrite_o, memtoreg_o,
               branch_o, illegal_o};
        checks++;
        if (state_o !== e.st || act !== e.c || retired_o !== e.r) begin
          failures++;
          $display("FAIL %s: got state=%0d ctl=%b retired=%0d, want state=%0d ctl=%b retired=%0d",
                   e.tag, state_o, act, retired_o, e.st, e.c, e.r);
        end
      end
    end
  end

  initial begin
    #100000;
    failures++;
    $display("FAIL timeout: wait expired before test completion");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  task automatic cyc(input string tag, input logic [6:0] op, input logic [2:0] f3,
                     input logic z, input logic rdy, input logic [2:0] st,
                     input logic [14:0] c);
    opcode_i = op; funct3_i = f3; zero_i = z; mem_ready_i = rdy;
    sb.push_back('{tag, st, c, ret});
    @(posedge clk); #1;
  endtask

  task automatic fetch(input logic [6:0] op, input int waits);
    for (int i = 0; i < waits; i++)
      cyc("fetch_wait", op, 3'b000, 1'b0, 1'b0, 3'd0, mk(1,0,0,0,0,0,0,2'b00,2'b00,0,0,0,0));
    cyc("fetch", op, 3'b000, 1'b0, 1'b1, 3'd0, mk(1,0,0,1,1,0,0,2'b01,2'b00,0,0,0,0));
  endtask

  task automatic decode(input logic [6:0] op, input logic [2:0] f3, input logic z);
    cyc("decode", op, f3, z, 1'b1, 3'd1, mk(0,0,0,0,0,0,0,2'b10,2'b00,0,0,0,0));
  endtask

  task automatic instr_alu(input logic [6:0] op);
    fetch(op, 0);
    decode(op, 3'b000, 1'b0);
    if (op == R) cyc("exec_r", op, 3'b000, 1'b0, 1'b1, 3'd2, mk(0,0,0,0,0,0,1,2'b00,2'b10,0,0,0,0));
    else         cyc("exec_i", op, 3'b000, 1'b0, 1'b1, 3'd2, mk(0,0,0,0,0,0,1,2'b10,2'b10,0,0,0,0));
    cyc("wb_alu", op, 3'b000, 1'b0, 1'b1, 3'd4, mk(0,0,0,0,0,0,0,2'b00,2'b00,1,0,0,0));
    ret++;
  endtask

  task automatic instr_load(input int fwaits, input int mwaits);
    fetch(LD, fwaits);
    decode(LD, 3'b010, 1'b0);
    cyc("exec_ld", LD, 3'b010, 1'b0, 1'b1, 3'd2, mk(0,0,0,0,0,0,1,2'b10,2'b00,0,0,0,0));
    for (int i = 0; i < mwaits; i++)
      cyc("mem_ld_wait", LD, 3'b010, 1'b0, 1'b0, 3'd3, mk(1,0,1,0,0,0,0,2'b00,2'b00,0,0,0,0));
    cyc("mem_ld", LD, 3'b010, 1'b0, 1'b1, 3'd3, mk(1,0,1,0,0,0,0,2'b00,2'b00,0,0,0,0));
    cyc("wb_ld", LD, 3'b010, 1'b0, 1'b1, 3'd4, mk(0,0,0,0,0,0,0,2'b00,2'b00,1,1,0,0));
    ret++;
  endtask

  task automatic instr_store(input int mwaits);
    fetch(ST, 0);
    decode(ST, 3'b010, 1'b0);
    cyc("exec_st", ST, 3'b010, 1'b0, 1'b1, 3'd2, mk(0,0,0,0,0,0,1,2'b10,2'b00,0,0,0,0));
    for (int i = 0; i < mwaits; i++)
      cyc("mem_st_wait", ST, 3'b010, 1'b0, 1'b0, 3'd3, mk(1,1,1,0,0,0,0,2'b00,2'b00,0,0,0,0));
    cyc("mem_st", ST, 3'b010, 1'b0, 1'b1, 3'd3, mk(1,1,1,0,0,0,0,2'b00,2'b00,0,0,0,0));
    ret++;
  endtask

  task automatic instr_branch(input logic [2:0] f3, input logic z, input logic taken);
    fetch(BR, 0);
    decode(BR, f3, z);
    cyc("exec_br", BR, f3, z, 1'b1, 3'd2, mk(0,0,0,0,taken,1,1,2'b00,2'b01,0,0,1,0));
    ret++;
  endtask

  task automatic reset_check(input string tag);
    logic [14:0] act;
    ret = '0;
    act = {mem_req_o, mem_we_o, iord_o, ir_we_o, pc_we_o, pcsrc_o,
           alusrca_o, alusrcb_o, aluop_o, regwrite_o, memtoreg_o,
           branch_o, illegal_o};
    checks++;
    if (state_o !== 3'd0 || act !== 15'd0 || retired_o !== '0) begin
      failures++;
      $display("FAIL %s: got state=%0d ctl=%b retired=%0d, want all zero",
               tag, state_o, act, retired_o);
    end
    #1;
  endtask

  initial begin
    rst_ni = 1'b0; opcode_i = R; funct3_i = '0; zero_i = 1'b0; mem_ready_i = 1'b1;
    #1 reset_check("reset_init");
    @(posedge clk); @(posedge clk); #1;
    rst_ni = 1'b1;

    instr_alu(R);
    instr_load(0, 3);
    instr_alu(IA);
    instr_branch(3'b000, 1'b1, 1'b1);
    instr_branch(3'b001, 1'b1, 1'b0);
    instr_branch(3'b001, 1'b0, 1'b1);
    fetch(BAD, 0);
    cyc("decode_ill", BAD, 3'b000, 1'b0, 1'b1, 3'd1, mk(0,0,0,0,0,0,0,2'b10,2'b00,0,0,0,1));
    instr_store(0);
    instr_load(2, 0);

    fetch(ST, 0);
    decode(ST, 3'b010, 1'b0);
    cyc("exec_st", ST, 3'b010, 1'b0, 1'b1, 3'd2, mk(0,0,0,0,0,0,1,2'b10,2'b00,0,0,0,0));
    opcode_i = ST; mem_ready_i = 1'b0;
    sb.push_back('{"mem_st_pre_rst", 3'd3, mk(1,1,1,0,0,0,0,2'b00,2'b00,0,0,0,0), ret});
    @(negedge clk); #2;
    rst_ni = 1'b0;
    #1 reset_check("reset_mid_mem");
    @(posedge clk); @(posedge clk); #1;
    rst_ni = 1'b1;

    for (int i = 0; i < 16; i++) instr_alu(R);
    fetch(R, 0);

    @(posedge clk); @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
